// File: rtl/game_timer_if.sv
// Control/status bundle between the round controller and the game timer.
interface game_timer_if;
  logic       start;
  logic       pause;
  logic       hit;
  logic [7:0] time_left;
  logic       running;
  logic       sec_tick;
  logic       game_over;
  logic       expired;

  modport master (
    output start, pause, hit,
    input  time_left, running, sec_tick, game_over, expired
  );

  modport slave (
    input  start, pause, hit,
    output time_left, running, sec_tick, game_over, expired
  );
endinterface

// File: rtl/game_timer.sv
// Whack-a-mole round countdown: 1 Hz prescaler, seconds counter, expiry pulse.
// Optional per-hit time bonus enabled by defining GAME_TIMER_BONUS_EN.
module game_timer #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int GAME_SECONDS  = 60,
  parameter int BONUS_SECONDS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  game_timer_if.slave  bus
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);
  localparam logic [8:0] FULL = 9'(GAME_SECONDS);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          tick_now;
  logic [8:0]    next_time;

  assign tick_now = (state == RUNNING) && !bus.pause && (presc == TERM);

`ifdef GAME_TIMER_BONUS_EN
  logic bonus_now;
  assign bonus_now = bus.hit && ((state == RUNNING) || (state == PAUSED));
`else
  logic hit_unused;
  assign hit_unused = bus.hit;
`endif

  // Bonus is added before the tick is taken so a hit on the last second rescues the round.
  always_comb begin
    next_time = {1'b0, bus.time_left};
`ifdef GAME_TIMER_BONUS_EN
    if (bonus_now)
      next_time = next_time + 9'(BONUS_SECONDS);
`endif
    if (tick_now)
      next_time = (next_time == 9'd0) ? 9'd0 : next_time - 9'd1;
    if (next_time > FULL)
      next_time = FULL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      presc         <= '0;
      bus.time_left <= 8'(GAME_SECONDS);
      bus.running   <= 1'b0;
      bus.sec_tick  <= 1'b0;
      bus.game_over <= 1'b0;
      bus.expired   <= 1'b0;
    end else begin
      bus.sec_tick  <= 1'b0;
      bus.game_over <= 1'b0;
      if (bus.start) begin
        state         <= RUNNING;
        presc         <= '0;
        bus.time_left <= 8'(GAME_SECONDS);
        bus.running   <= 1'b1;
        bus.expired   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            presc         <= '0;
            bus.time_left <= 8'(GAME_SECONDS);
          end
          RUNNING: begin
            bus.time_left <= next_time[7:0];
            if (bus.pause) begin
              state <= PAUSED;
            end else if (tick_now) begin
              presc        <= '0;
              bus.sec_tick <= 1'b1;
              if (next_time == 9'd0) begin
                state         <= EXPIRED;
                bus.game_over <= 1'b1;
                bus.running   <= 1'b0;
                bus.expired   <= 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          PAUSED: begin
            bus.time_left <= next_time[7:0];
            if (!bus.pause)
              state <= RUNNING;
          end
          EXPIRED: begin
            bus.time_left <= 8'd0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_timer.sv
// Randomised and directed bench for game_timer against a seconds/phase reference model.
module tb_game_timer;
  localparam int CLK_HZ = 4;
  localparam int GS     = 3;
  localparam int BS     = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  game_timer_if bus ();

  game_timer #(.CLK_HZ(CLK_HZ), .GAME_SECONDS(GS), .BONUS_SECONDS(BS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: seconds left, cycles into the current second, round status.
  int m_time, m_phase;
  bit m_active, m_paused, m_expired, m_tick, m_over;

  task automatic model_reset();
    m_time = GS; m_phase = 0; m_active = 0; m_paused = 0;
    m_expired = 0; m_tick = 0; m_over = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit h);
    int t;
    m_tick = 0; m_over = 0;
    if (s) begin
      m_time = GS; m_phase = 0; m_active = 1; m_paused = 0; m_expired = 0;
    end else if (m_active) begin
      t = m_time;
`ifdef GAME_TIMER_BONUS_EN
      if (h) t = t + BS;
`endif
      if (m_paused) m_paused = p;
      else if (p) m_paused = 1;
      else begin
        m_phase++;
        if (m_phase == CLK_HZ) begin
          m_phase = 0;
          m_tick = 1;
        end
      end
      if (m_tick && t > 0) t = t - 1;
      if (t > GS) t = GS;
      m_time = t;
      if (m_tick && t == 0) begin
        m_active = 0; m_expired = 1; m_over = 1;
      end
    end
  endtask

  task automatic check_output(input string tag);
    tests += 5;
    assert (bus.time_left === 8'(m_time)) else begin
      fails++; $error("[TB] FAIL %s time_left got %0d want %0d", tag, bus.time_left, m_time);
    end
    assert (bus.running === m_active) else begin
      fails++; $error("[TB] FAIL %s running got %b want %b", tag, bus.running, m_active);
    end
    assert (bus.sec_tick === m_tick) else begin
      fails++; $error("[TB] FAIL %s sec_tick got %b want %b", tag, bus.sec_tick, m_tick);
    end
    assert (bus.game_over === m_over) else begin
      fails++; $error("[TB] FAIL %s game_over got %b want %b", tag, bus.game_over, m_over);
    end
    assert (bus.expired === m_expired) else begin
      fails++; $error("[TB] FAIL %s expired got %b want %b", tag, bus.expired, m_expired);
    end
  endtask

  task automatic apply_stimulus(input bit s, input bit p, input bit h, input string tag);
    bus.start = s; bus.pause = p; bus.hit = h;
    @(posedge clk);
    model_step(s, p, h);
    #1;
    check_output(tag);
  endtask

  task automatic run_cycles(input int n, input bit p, input string tag);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, p, 1'b0, tag);
  endtask

  initial begin
    bus.start = 0; bus.pause = 0; bus.hit = 0;
    model_reset();
    #12;
    check_output("reset");
    rst_n = 1'b1;

    // idle: hits and pause must not disturb anything
    for (int i = 0; i < 20; i++)
      apply_stimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "idle");

    // full round to expiry, then linger in EXPIRED with hits
    apply_stimulus(1'b1, 1'b0, 1'b0, "start");
    run_cycles(14, 1'b0, "countdown");
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 1'b1, "expired_hold");

    // pause mid-second, then release
    apply_stimulus(1'b1, 1'b0, 1'b0, "restart_expired");
    run_cycles(6, 1'b0, "pre_pause");
    run_cycles(10, 1'b1, "paused");
    run_cycles(12, 1'b0, "post_pause");

    // start coincident with a tick
    apply_stimulus(1'b1, 1'b0, 1'b0, "start2");
    run_cycles(3, 1'b0, "to_tick");
    apply_stimulus(1'b1, 1'b0, 1'b0, "start_on_tick");
    run_cycles(2, 1'b0, "after_start_tick");

    // hits at time_left=2 and hit coincident with the 1->0 tick
    apply_stimulus(1'b1, 1'b0, 1'b0, "start3");
    run_cycles(4, 1'b0, "to_two");
    apply_stimulus(1'b0, 1'b0, 1'b1, "hit_at_two");
    run_cycles(6, 1'b0, "to_one");
    apply_stimulus(1'b0, 1'b0, 1'b1, "hit_on_tick");
    run_cycles(16, 1'b0, "after_bonus");

    // random traffic
    for (int i = 0; i < 400; i++)
      apply_stimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 6) == 0), "random");

    // asynchronous reset in the middle of a round
    apply_stimulus(1'b1, 1'b0, 1'b0, "start4");
    run_cycles(5, 1'b0, "pre_reset");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_output("async_reset");
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_output("reset_held");
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    run_cycles(5, 1'b0, "post_reset_idle");
    apply_stimulus(1'b1, 1'b0, 1'b0, "start5");
    run_cycles(14, 1'b0, "final_round");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
